mm_host_master: RTL and testbench
=================================

// Module: mm_host_master
// PURPOSE
//  Initiator side of the QoS-control memory-mapped register bus. Turns single host
//  commands (valid/ready) into one-cycle mm_write_en/mm_read_en strobes, returns read
//  data, and autonomously polls STATUS (active channel/signal present) and ERROR
//  (per-channel error counts) every POLL_PERIOD cycles for the supervisory logic.
// PARAMETERS
//  POLL_PERIOD   1000   poll interval in clk cycles (>=2); shorter than a poll = polls back-to-back
//  STATUS_ADDR   8'h01  register address read first in each poll
//  ERROR_ADDR    8'h02  register address read second in each poll
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  cmd_valid     in   1   host command present
//  cmd_ready     out  1   command accepted on clk edge where valid&ready
//  cmd_write     in   1   1=write, 0=read
//  cmd_addr      in   8   register address
//  cmd_wdata     in   32  write data
//  rsp_valid     out  1   one-cycle pulse: command done (write ack or read data)
//  rsp_rdata     out  32  read data (held until next read response; 0 on write ack)
//  poll_enable   in   1   enables periodic polling
//  status_word   out  32  last polled STATUS register
//  error_word    out  32  last polled ERROR register
//  status_valid  out  1   one-cycle pulse: status_word and error_word both just updated
//  busy          out  1   FSM not in IDLE
//  mm_write_en   out  1   bus write strobe
//  mm_read_en    out  1   bus read strobe
//  mm_addr       out  8   bus address
//  mm_wdata      out  32  bus write data
//  mm_rdata      in   32  bus read data; valid the cycle after the mm_read_en cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, FSM=IDLE, poll timer=0, poll_pending=0;
//    in-flight command dropped, no rsp_valid for it.
//  - All mm_* outputs registered. mm_addr/mm_wdata hold their last value between strobes.
//  - FSM: IDLE, WR, RD, RD_CAP, PS, PS_CAP, PE, PE_CAP.
//  - cmd_ready = (state==IDLE) && !poll_pending. Accept at edge e0 -> WR or RD.
//  - WR: mm_write_en=1 for exactly 1 cycle (cycle after e0); at its end -> IDLE,
//    rsp_valid=1 next cycle (rsp_rdata=0). Write throughput: 1 cmd / 2 cycles.
//  - RD: mm_read_en=1 one cycle -> RD_CAP (slave registers rdata) -> at end of RD_CAP
//    rsp_rdata<=mm_rdata, rsp_valid=1 next cycle, state IDLE. Strobe-to-rsp_valid = 2 cycles.
//  - Poll timer: counts while poll_enable=1, independent of FSM; at POLL_PERIOD-1 wraps
//    to 0 and sets poll_pending. poll_enable=0 clears timer and a not-yet-started pending.
//  - Priority: in IDLE, poll_pending wins over cmd_valid (cmd stays pending, not lost).
//  - Poll: PS(read STATUS_ADDR) -> PS_CAP(capture to temp) -> PE(read ERROR_ADDR) ->
//    PE_CAP(capture) -> IDLE; at end of PE_CAP status_word and error_word update
//    together, status_valid pulses next cycle; poll_pending cleared on entering PS.
//  - Started poll always completes even if poll_enable drops. Poll never drives rsp_valid.
//  - Timer expiry during a poll re-sets poll_pending (max one queued; extras dropped).
//  - Never more than one of mm_write_en/mm_read_en high; never on consecutive cycles
//    within one transaction.
// TESTING
//  1. Write addr 0x00 data 0x0001_2345 -> mm_write_en high exactly 1 cycle after accept,
//     mm_addr=0x00, mm_wdata=0x0001_2345; rsp_valid pulse next cycle; cmd_ready low meanwhile.
//  2. Read 0x02, slave model returns 0xAABB_CCDD -> mm_read_en 1 cycle; rsp_valid 2 cycles
//     later with rsp_rdata=0xAABB_CCDD.
//  3. POLL_PERIOD=16, poll_enable=1, STATUS=0x0000_0035, ERROR=0x0403_0201 -> status_valid
//     every 16 cycles, status_word=0x35, error_word=0x0403_0201, reads at 0x01 then 0x02.
//  4. cmd_valid rises in the cycle poll_pending sets -> poll runs first, then the command
//     is accepted and completes; exactly one rsp_valid, one status_valid.
//  5. rst_n low during RD_CAP -> all outputs 0 immediately; no rsp_valid after release;
//     next read completes normally.
//  6. poll_enable dropped during PE -> status_valid still pulses once; no further polls.

Source files
------------

// File: rtl/mm_host_master.sv
// mm_host_master: initiator on the QoS-control register bus.
// Converts single host commands (valid/ready) into one-cycle mm_write_en /
// mm_read_en strobes and returns read data. Also polls STATUS and ERROR every
// POLL_PERIOD cycles and publishes both words together for supervisory logic.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/write      host command handshake and direction
//   cmd_addr, cmd_wdata        host command address / write data
//   rsp_valid, rsp_rdata       command completion pulse / read data
//   poll_enable                enables the periodic poll
//   status_word, error_word    last polled register values
//   status_valid               pulse: both poll words just updated
//   busy                       FSM is not idle
//   mm_write_en/read_en        bus strobes
//   mm_addr, mm_wdata          bus address / write data (held between strobes)
//   mm_rdata                   bus read data, valid the cycle after mm_read_en
module mm_host_master #(
  parameter int unsigned POLL_PERIOD = 1000,
  parameter logic [7:0]  STATUS_ADDR = 8'h01,
  parameter logic [7:0]  ERROR_ADDR  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        poll_enable,
  output logic [31:0] status_word,
  output logic [31:0] error_word,
  output logic        status_valid,
  output logic        busy,
  output logic        mm_write_en,
  output logic        mm_read_en,
  output logic [7:0]  mm_addr,
  output logic [31:0] mm_wdata,
  input  logic [31:0] mm_rdata
);

  localparam int unsigned TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RD_CAP, PS, PS_CAP, PE, PE_CAP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          poll_pending_q, poll_pending_d;
  logic [31:0]   status_tmp_q, status_tmp_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [31:0]   status_word_q, status_word_d;
  logic [31:0]   error_word_q, error_word_d;
  logic          status_valid_q, status_valid_d;
  logic          busy_q, busy_d;
  logic          mm_write_en_q, mm_write_en_d;
  logic          mm_read_en_q, mm_read_en_d;
  logic [7:0]    mm_addr_q, mm_addr_d;
  logic [31:0]   mm_wdata_q, mm_wdata_d;

  logic          timer_expire;
  logic          start_poll;

  // Next-state, strobes, poll timer and response/poll capture
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    poll_pending_d = poll_pending_q;
    status_tmp_d   = status_tmp_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    status_word_d  = status_word_q;
    error_word_d   = error_word_q;
    status_valid_d = 1'b0;
    mm_write_en_d  = 1'b0;
    mm_read_en_d   = 1'b0;
    mm_addr_d      = mm_addr_q;
    mm_wdata_d     = mm_wdata_q;

    timer_expire = poll_enable && (timer_q == TIMER_MAX);
    start_poll   = (state_q == IDLE) && poll_pending_q && poll_enable;

    if (!poll_enable || timer_expire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        // A pending poll outranks a waiting command; the command stays queued.
        if (start_poll) begin
          state_d      = PS;
          mm_read_en_d = 1'b1;
          mm_addr_d    = STATUS_ADDR;
        end else if (cmd_valid && cmd_ready_q) begin
          mm_addr_d = cmd_addr;
          if (cmd_write) begin
            state_d       = WR;
            mm_write_en_d = 1'b1;
            mm_wdata_d    = cmd_wdata;
          end else begin
            state_d      = RD;
            mm_read_en_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      RD:     state_d = RD_CAP;
      RD_CAP: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = mm_rdata;
      end
      PS:     state_d = PS_CAP;
      PS_CAP: begin
        status_tmp_d = mm_rdata;
        state_d      = PE;
        mm_read_en_d = 1'b1;
        mm_addr_d    = ERROR_ADDR;
      end
      PE:     state_d = PE_CAP;
      PE_CAP: begin
        status_word_d  = status_tmp_q;
        error_word_d   = mm_rdata;
        status_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Expiry outranks the clear on poll start so at most one poll stays queued.
    if (!poll_enable) begin
      poll_pending_d = 1'b0;
    end else if (timer_expire) begin
      poll_pending_d = 1'b1;
    end else if (start_poll) begin
      poll_pending_d = 1'b0;
    end

    cmd_ready_d = (state_d == IDLE) && !poll_pending_d;
    busy_d      = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      timer_q        <= '0;
      poll_pending_q <= 1'b0;
      status_tmp_q   <= '0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      status_word_q  <= '0;
      error_word_q   <= '0;
      status_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      mm_write_en_q  <= 1'b0;
      mm_read_en_q   <= 1'b0;
      mm_addr_q      <= '0;
      mm_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      poll_pending_q <= poll_pending_d;
      status_tmp_q   <= status_tmp_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      status_word_q  <= status_word_d;
      error_word_q   <= error_word_d;
      status_valid_q <= status_valid_d;
      busy_q         <= busy_d;
      mm_write_en_q  <= mm_write_en_d;
      mm_read_en_q   <= mm_read_en_d;
      mm_addr_q      <= mm_addr_d;
      mm_wdata_q     <= mm_wdata_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign status_word  = status_word_q;
  assign error_word   = error_word_q;
  assign status_valid = status_valid_q;
  assign busy         = busy_q;
  assign mm_write_en  = mm_write_en_q;
  assign mm_read_en   = mm_read_en_q;
  assign mm_addr      = mm_addr_q;
  assign mm_wdata     = mm_wdata_q;

endmodule

// File: tb/tb_mm_host_master.sv
// tb_mm_host_master: directed and randomized checks of mm_host_master against
// a register-file reference and cycle arithmetic derived from the bus rules.
module tb_mm_host_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        poll_enable;
  logic [31:0] status_word;
  logic [31:0] error_word;
  logic        status_valid;
  logic        busy;
  logic        mm_write_en;
  logic        mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;

  int vectors;
  int miscompares;

  // Reference register contents as the host believes them to be
  logic [31:0] ref_mem [256];
  // Slave register file, written only through the bus
  logic [31:0] slave_mem [256];

  // Bus monitor results
  int          proto_err;
  int          rd_n;
  logic [7:0]  rd_log [$];
  logic        prev_strobe;

  mm_host_master #(
    .POLL_PERIOD(16),
    .STATUS_ADDR(8'h01),
    .ERROR_ADDR (8'h02)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .poll_enable (poll_enable),
    .status_word (status_word),
    .error_word  (error_word),
    .status_valid(status_valid),
    .busy        (busy),
    .mm_write_en (mm_write_en),
    .mm_read_en  (mm_read_en),
    .mm_addr     (mm_addr),
    .mm_wdata    (mm_wdata),
    .mm_rdata    (mm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: data is valid only in the cycle after the read strobe, junk otherwise
  always @(posedge clk) begin
    if (mm_write_en) slave_mem[mm_addr] <= mm_wdata;
    mm_rdata <= mm_read_en ? slave_mem[mm_addr] : $urandom;
  end

  // Strobe exclusivity / spacing and read-address log
  initial begin
    proto_err   = 0;
    rd_n        = 0;
    prev_strobe = 1'b0;
  end
  always @(negedge clk) begin
    if (mm_write_en && mm_read_en) proto_err++;
    if ((mm_write_en || mm_read_en) && prev_strobe) proto_err++;
    prev_strobe = mm_write_en || mm_read_en;
    if (mm_read_en) begin
      rd_log.push_back(mm_addr);
      rd_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one command starting at a negedge; returns at the response negedge.
  task automatic run_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         output int waits);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    waits     = 0;
    while (!cmd_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    chk("accept_timeout", 32'(waits < 64), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wr) begin
      chk("wr_strobe", 32'({mm_write_en, mm_read_en, cmd_ready, busy}), 32'b1001);
      chk("wr_addr", 32'(mm_addr), 32'(a));
      chk("wr_data", mm_wdata, d);
      ref_mem[a] = d;
      @(negedge clk);
      chk("wr_rsp", 32'({rsp_valid, mm_write_en}), 32'b10);
      chk("wr_rdata", rsp_rdata, 32'd0);
    end else begin
      chk("rd_strobe", 32'({mm_write_en, mm_read_en, cmd_ready, busy}), 32'b0101);
      chk("rd_addr", 32'(mm_addr), 32'(a));
      @(negedge clk);
      chk("rd_gap", 32'({rsp_valid, mm_read_en}), 32'd0);
      @(negedge clk);
      chk("rd_rsp", 32'(rsp_valid), 32'd1);
      chk("rd_data", rsp_rdata, ref_mem[a]);
    end
  endtask

  int          w;
  int          n;
  int          base;
  int          svn;
  int          rspn;
  int          sv_at;
  int          rsp_at;
  int          rds;
  logic        taken;
  logic        wr;
  logic [7:0]  a;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    poll_enable = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_flags", 32'({cmd_ready, rsp_valid, status_valid, busy, mm_write_en, mm_read_en}), 32'd0);
    chk("rst_words", status_word | error_word | rsp_rdata | mm_wdata | 32'(mm_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, then back-to-back write throughput
    run_cmd(1'b1, 8'h00, 32'h0001_2345, w);
    run_cmd(1'b1, 8'h03, 32'h5A5A_0003, w);
    chk("wr_throughput_waits", 32'(w), 32'd0);

    // Read back through the slave
    run_cmd(1'b1, 8'h02, 32'hAABB_CCDD, w);
    run_cmd(1'b0, 8'h02, 32'h0, w);
    run_cmd(1'b0, 8'h00, 32'h0, w);

    // Periodic poll
    run_cmd(1'b1, 8'h01, 32'h0000_0035, w);
    run_cmd(1'b1, 8'h02, 32'h0403_0201, w);
    poll_enable = 1'b1;
    n = 0;
    while (!status_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("poll_first_timeout", 32'(n < 64), 32'd1);
    #1;
    base = rd_n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!status_valid && n < 64);
    chk("poll_period", 32'(n), 32'd16);
    chk("status_word", status_word, 32'h0000_0035);
    chk("error_word", error_word, 32'h0403_0201);
    #1;
    chk("poll_read_count", 32'(rd_n - base), 32'd2);
    if (rd_n - base >= 2) begin
      chk("poll_read0_addr", 32'(rd_log[base]), 32'h01);
      chk("poll_read1_addr", 32'(rd_log[base + 1]), 32'h02);
    end

    // Command raised in the cycle a poll becomes pending: poll first
    repeat (11) @(negedge clk);
    chk("cmd_ready_masked", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h20;
    cmd_wdata = $urandom;
    svn = 0; rspn = 0; sv_at = -1; rsp_at = -1;
    for (int k = 1; k <= 12; k++) begin
      taken = cmd_valid && cmd_ready;
      @(negedge clk);
      if (taken) cmd_valid = 1'b0;
      if (status_valid) begin svn++; sv_at = k; end
      if (rsp_valid) begin rspn++; rsp_at = k; end
    end
    chk("race_sv_count", 32'(svn), 32'd1);
    chk("race_rsp_count", 32'(rspn), 32'd1);
    chk("race_sv_cycle", 32'(sv_at), 32'd5);
    chk("race_rsp_cycle", 32'(rsp_at), 32'd7);
    ref_mem[8'h20] = cmd_wdata;

    // poll_enable dropped in the ERROR read cycle
    n = 0;
    while (!(mm_read_en && mm_addr == 8'h02) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("pe_wait_timeout", 32'(n < 64), 32'd1);
    poll_enable = 1'b0;
    svn = 0; rds = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (status_valid) svn++;
      if (mm_read_en) rds++;
    end
    chk("drop_sv_count", 32'(svn), 32'd1);
    chk("drop_no_more_reads", 32'(rds), 32'd0);

    // Reset during RD_CAP
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h02;
    n = 0;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_flags", 32'({cmd_ready, rsp_valid, status_valid, busy, mm_write_en, mm_read_en}), 32'd0);
    chk("rstmid_words", status_word | error_word | rsp_rdata | mm_wdata | 32'(mm_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rspn = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) rspn++;
    end
    chk("rstmid_no_rsp", 32'(rspn), 32'd0);
    run_cmd(1'b0, 8'h02, 32'h0, w);

    // Randomized traffic against the reference register file
    for (int i = 0; i < 8; i++) run_cmd(1'b1, 8'(8'h10 + i), $urandom, w);
    for (int i = 0; i < 30; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'(8'h10 + $urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(wr, a, $urandom, w);
    end

    repeat (2) @(negedge clk);
    chk("bus_protocol", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
